// File: rtl/booth_dot_acc.sv
// booth_dot_acc
// Accumulates the signed products coming out of a Booth multiplier into a
// dot-product sum. A product is taken on each rising edge of the
// multiplier's ready level. After N_TERMS products the sum is offered on a
// valid/ready result port. While the sum is pending, stall tells the operand
// issuer to hold off.
//
// Parameters
//   BIT_LEN   multiplier operand width (products are 2*BIT_LEN bits, signed)
//   ACC_LEN   accumulator width, at least 2*BIT_LEN
//   N_TERMS   products per result, at least 1
// Ports
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   clr        synchronous batch abort; drops the partial sum, any pending
//              result and a product detected in the same cycle
//   prod       product from the multiplier
//   prod_r     multiplier ready level; its rising edge marks a new product
//   acc_ready  downstream accepts the result
//   acc_out    registered accumulator value
//   acc_valid  result pending
//   ovf        sticky signed overflow within the current batch
//   lost       sticky: a product arrived while a result was pending
//   stall      upstream must not start a new multiplication
//   term_cnt   products accepted in the current batch (holds N_TERMS-1
//              while a result is pending)
module booth_dot_acc #(
    parameter int BIT_LEN = 4,
    parameter int ACC_LEN = 10,
    parameter int N_TERMS = 4,
    localparam int CW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   clr,
    input  logic [2*BIT_LEN-1:0]   prod,
    input  logic                   prod_r,
    input  logic                   acc_ready,
    output logic [ACC_LEN-1:0]     acc_out,
    output logic                   acc_valid,
    output logic                   ovf,
    output logic                   lost,
    output logic                   stall,
    output logic [CW-1:0]          term_cnt
);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Signed overflow of a two's complement addition, judged from sign bits.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                     input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [ACC_LEN-1:0] acc_r;
    logic [ACC_LEN-1:0] acc_s;
    logic [CW-1:0]      cnt_r;
    logic [CW-1:0]      cnt_s;
    logic               ovf_r;
    logic               ovf_s;
    logic               lost_r;
    logic               lost_s;
    logic               prod_r_q_r;

    logic               det_s;
    logic [ACC_LEN-1:0] prod_ext_s;
    logic [ACC_LEN-1:0] base_acc_s;
    logic [CW-1:0]      base_cnt_s;
    logic               base_ovf_s;
    logic [ACC_LEN-1:0] sum_s;
    logic               last_s;
    logic               add_ovf_s;

    assign det_s      = prod_r & ~prod_r_q_r;
    assign prod_ext_s = ACC_LEN'($signed(prod));

    // Starting point for an accepted product: the running batch in ACCUM, or
    // an empty batch when a product rides on the handshake out of HOLD.
    always_comb begin
        base_acc_s = acc_r;
        base_cnt_s = cnt_r;
        base_ovf_s = ovf_r;
        if (state_r == ST_HOLD) begin
            base_acc_s = {ACC_LEN{1'b0}};
            base_cnt_s = {CW{1'b0}};
            base_ovf_s = 1'b0;
        end else begin
            base_acc_s = acc_r;
            base_cnt_s = cnt_r;
            base_ovf_s = ovf_r;
        end
    end

    assign sum_s     = base_acc_s + prod_ext_s;
    assign add_ovf_s = add_ovf(base_acc_s[ACC_LEN-1], prod_ext_s[ACC_LEN-1],
                               sum_s[ACC_LEN-1]);
    // The product being accepted is the last one of its batch.
    assign last_s    = (base_cnt_s == CW'(N_TERMS - 1));

    // Next-state and next-datapath decision.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        cnt_s   = cnt_r;
        ovf_s   = ovf_r;
        lost_s  = lost_r;
        if (clr) begin
            state_s = ST_ACCUM;
            acc_s   = {ACC_LEN{1'b0}};
            cnt_s   = {CW{1'b0}};
            ovf_s   = 1'b0;
            lost_s  = 1'b0;
        end else begin
            case (state_r)
                ST_ACCUM: begin
                    if (det_s) begin
                        acc_s = sum_s;
                        ovf_s = base_ovf_s | add_ovf_s;
                        if (last_s) begin
                            // count saturates at N_TERMS-1 while held
                            state_s = ST_HOLD;
                            cnt_s   = base_cnt_s;
                        end else begin
                            state_s = ST_ACCUM;
                            cnt_s   = base_cnt_s + CW'(1);
                        end
                    end else begin
                        state_s = ST_ACCUM;
                    end
                end
                ST_HOLD: begin
                    if (acc_ready) begin
                        if (det_s) begin
                            // product becomes the first term of a new batch
                            acc_s = sum_s;
                            ovf_s = base_ovf_s | add_ovf_s;
                            if (last_s) begin
                                state_s = ST_HOLD;
                                cnt_s   = base_cnt_s;
                            end else begin
                                state_s = ST_ACCUM;
                                cnt_s   = base_cnt_s + CW'(1);
                            end
                        end else begin
                            state_s = ST_ACCUM;
                            acc_s   = {ACC_LEN{1'b0}};
                            cnt_s   = {CW{1'b0}};
                            ovf_s   = 1'b0;
                        end
                    end else if (det_s) begin
                        lost_s = 1'b1;
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                default: begin
                    state_s = ST_ACCUM;
                    acc_s   = {ACC_LEN{1'b0}};
                    cnt_s   = {CW{1'b0}};
                    ovf_s   = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_ACCUM;
            acc_r   <= {ACC_LEN{1'b0}};
            cnt_r   <= {CW{1'b0}};
            ovf_r   <= 1'b0;
            lost_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            cnt_r   <= cnt_s;
            ovf_r   <= ovf_s;
            lost_r  <= lost_s;
        end
    end

    // Delayed ready level for edge detection; resets high so a level already
    // present when reset releases is not mistaken for a new product.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prod_r_q_r <= 1'b1;
        end else begin
            prod_r_q_r <= prod_r;
        end
    end

    assign acc_out   = acc_r;
    assign acc_valid = (state_r == ST_HOLD);
    assign stall     = (state_r == ST_HOLD);
    assign ovf       = ovf_r;
    assign lost      = lost_r;
    assign term_cnt  = cnt_r;

endmodule

// File: tb/tb_booth_dot_acc.sv
module tb_booth_dot_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic       clr;
    logic       prod_r;
    logic       acc_ready;
    logic [7:0] prod;

    // u0: defaults, u1: ACC_LEN=8 N_TERMS=2, u2: ACC_LEN=8 N_TERMS=1
    logic [9:0] acc_out0;
    logic       acc_valid0, ovf0, lost0, stall0;
    logic [1:0] term_cnt0;
    logic [7:0] acc_out1;
    logic       acc_valid1, ovf1, lost1, stall1;
    logic [0:0] term_cnt1;
    logic [7:0] acc_out2;
    logic       acc_valid2, ovf2, lost2, stall2;
    logic [0:0] term_cnt2;

    booth_dot_acc #(.BIT_LEN(4), .ACC_LEN(10), .N_TERMS(4)) u0 (
        .clk(clk), .rstn(rstn), .clr(clr), .prod(prod), .prod_r(prod_r),
        .acc_ready(acc_ready), .acc_out(acc_out0), .acc_valid(acc_valid0),
        .ovf(ovf0), .lost(lost0), .stall(stall0), .term_cnt(term_cnt0));

    booth_dot_acc #(.BIT_LEN(4), .ACC_LEN(8), .N_TERMS(2)) u1 (
        .clk(clk), .rstn(rstn), .clr(clr), .prod(prod), .prod_r(prod_r),
        .acc_ready(acc_ready), .acc_out(acc_out1), .acc_valid(acc_valid1),
        .ovf(ovf1), .lost(lost1), .stall(stall1), .term_cnt(term_cnt1));

    booth_dot_acc #(.BIT_LEN(4), .ACC_LEN(8), .N_TERMS(1)) u2 (
        .clk(clk), .rstn(rstn), .clr(clr), .prod(prod), .prod_r(prod_r),
        .acc_ready(acc_ready), .acc_out(acc_out2), .acc_valid(acc_valid2),
        .ovf(ovf2), .lost(lost2), .stall(stall2), .term_cnt(term_cnt2));

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain integer sum per instance, batch count and flags.
    int nt[3] = '{4, 2, 1};
    int al[3] = '{10, 8, 8};
    int m_acc[3];
    int m_cnt[3];
    bit m_hold[3];
    bit m_ovf[3];
    bit m_lost[3];
    bit m_prev;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_acc[i] = 0; m_cnt[i] = 0; m_hold[i] = 1'b0;
            m_ovf[i] = 1'b0; m_lost[i] = 1'b0;
        end
        m_prev = 1'b1;
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_step();
        bit det;
        int md, half, s, v, p;
        if (!rstn) begin
            model_reset();
            return;
        end
        det = prod_r && !m_prev;
        m_prev = prod_r;
        p = int'($signed(prod));
        for (int i = 0; i < 3; i++) begin
            if (clr) begin
                m_acc[i] = 0; m_cnt[i] = 0; m_hold[i] = 1'b0;
                m_ovf[i] = 1'b0; m_lost[i] = 1'b0;
            end else begin
                if (m_hold[i] && acc_ready) begin
                    m_hold[i] = 1'b0; m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 1'b0;
                end
                if (det) begin
                    if (m_hold[i]) begin
                        m_lost[i] = 1'b1;
                    end else begin
                        md   = 1 << al[i];
                        half = md / 2;
                        s    = (m_acc[i] >= half) ? m_acc[i] - md : m_acc[i];
                        v    = s + p;
                        if (v >= half || v < -half) m_ovf[i] = 1'b1;
                        m_acc[i] = ((v % md) + md) % md;
                        m_cnt[i]++;
                        if (m_cnt[i] == nt[i]) m_hold[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic cmp(input int i, input logic [31:0] acc, input logic vld,
                       input logic ov, input logic ls, input logic st,
                       input logic [31:0] cnt);
        chk($sformatf("u%0d.acc_out", i), acc, m_acc[i]);
        chk($sformatf("u%0d.acc_valid", i), {31'd0, vld}, {31'd0, m_hold[i]});
        chk($sformatf("u%0d.stall", i), {31'd0, st}, {31'd0, m_hold[i]});
        chk($sformatf("u%0d.ovf", i), {31'd0, ov}, {31'd0, m_ovf[i]});
        chk($sformatf("u%0d.lost", i), {31'd0, ls}, {31'd0, m_lost[i]});
        chk($sformatf("u%0d.term_cnt", i), cnt, m_hold[i] ? nt[i] - 1 : m_cnt[i]);
    endtask

    // Compare every instance against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, {22'd0, acc_out0}, acc_valid0, ovf0, lost0, stall0, {30'd0, term_cnt0});
            cmp(1, {24'd0, acc_out1}, acc_valid1, ovf1, lost1, stall1, {31'd0, term_cnt1});
            cmp(2, {24'd0, acc_out2}, acc_valid2, ovf2, lost2, stall2, {31'd0, term_cnt2});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    // One multiplier run: ready low for a cycle, then high with the product.
    task automatic product(input logic [7:0] p);
        prod_r = 1'b0;
        tick();
        prod_r = 1'b1;
        prod   = p;
        tick();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; clr = 1'b0; prod_r = 1'b0; acc_ready = 1'b0; prod = 8'h00;
        model_reset();
        tick();
        tick();
        chk_en = 1'b1;
        rstn = 1'b1;
        chk("reset_acc_out", {22'd0, acc_out0}, 32'd0);
        chk("reset_acc_valid", {31'd0, acc_valid0}, 32'd0);
        chk("reset_term_cnt", {30'd0, term_cnt0}, 32'd0);

        // basic dot product: four times 7 x (-5)
        product(8'hDD);
        chk("t1_acc_1", {22'd0, acc_out0}, 32'h3DD);
        chk("t1_cnt_1", {30'd0, term_cnt0}, 32'd1);
        product(8'hDD);
        chk("t1_acc_2", {22'd0, acc_out0}, 32'h3BA);
        product(8'hDD);
        chk("t1_acc_3", {22'd0, acc_out0}, 32'h397);
        chk("t1_valid_3", {31'd0, acc_valid0}, 32'd0);
        product(8'hDD);
        chk("t1_acc_4", {22'd0, acc_out0}, 32'h374);
        chk("t1_valid_4", {31'd0, acc_valid0}, 32'd1);
        chk("t1_stall_4", {31'd0, stall0}, 32'd1);
        chk("t1_ovf_4", {31'd0, ovf0}, 32'd0);
        chk("t1_cnt_4", {30'd0, term_cnt0}, 32'd3);
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        chk("t1_acc_hs", {22'd0, acc_out0}, 32'd0);
        chk("t1_valid_hs", {31'd0, acc_valid0}, 32'd0);

        // overflow on the 8-bit, two-term instance
        do_clr();
        product(8'h40);
        product(8'h40);
        chk("t2_acc", {24'd0, acc_out1}, 32'h80);
        chk("t2_ovf", {31'd0, ovf1}, 32'd1);
        chk("t2_valid", {31'd0, acc_valid1}, 32'd1);
        chk("t2_wide_acc", {22'd0, acc_out0}, 32'h080);
        chk("t2_wide_ovf", {31'd0, ovf0}, 32'd0);
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        chk("t2_ovf_hs", {31'd0, ovf1}, 32'd0);
        chk("t2_valid_hs", {31'd0, acc_valid1}, 32'd0);

        // a held-high level counts once
        prod_r = 1'b0;
        do_clr();
        prod_r = 1'b1;
        prod = 8'h03;
        repeat (5) tick();
        prod_r = 1'b0;
        tick();
        chk("t3_acc", {22'd0, acc_out0}, 32'd3);
        chk("t3_cnt", {30'd0, term_cnt0}, 32'd1);

        // product while held is lost; product on handshake starts new batch
        do_clr();
        repeat (4) product(8'h01);
        chk("t4_valid", {31'd0, acc_valid0}, 32'd1);
        product(8'h05);
        chk("t4_lost", {31'd0, lost0}, 32'd1);
        chk("t4_acc_frozen", {22'd0, acc_out0}, 32'd4);
        prod_r = 1'b0;
        tick();
        prod_r = 1'b1;
        prod = 8'h09;
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        chk("t4_acc_new", {22'd0, acc_out0}, 32'd9);
        chk("t4_cnt_new", {30'd0, term_cnt0}, 32'd1);
        chk("t4_lost_kept", {31'd0, lost0}, 32'd1);
        chk("t4_valid_new", {31'd0, acc_valid0}, 32'd0);

        // clr together with a product edge
        do_clr();
        product(8'h02);
        product(8'h02);
        chk("t5_cnt_pre", {30'd0, term_cnt0}, 32'd2);
        prod_r = 1'b0;
        tick();
        prod_r = 1'b1;
        prod = 8'h07;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t5_acc", {22'd0, acc_out0}, 32'd0);
        chk("t5_cnt", {30'd0, term_cnt0}, 32'd0);
        chk("t5_lost", {31'd0, lost0}, 32'd0);
        repeat (3) tick();
        chk("t5_acc_later", {22'd0, acc_out0}, 32'd0);

        // asynchronous reset mid-batch with the ready level high
        product(8'h05);
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        chk("t6_acc_async", {22'd0, acc_out0}, 32'd0);
        chk("t6_cnt_async", {30'd0, term_cnt0}, 32'd0);
        tick();
        tick();
        rstn = 1'b1;
        tick();
        tick();
        chk("t6_acc_rel", {22'd0, acc_out0}, 32'd0);
        chk("t6_cnt_rel", {30'd0, term_cnt0}, 32'd0);
        product(8'h05);
        chk("t6_acc_after", {22'd0, acc_out0}, 32'd5);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            prod_r    = 1'($urandom_range(0, 1));
            prod      = 8'($urandom);
            acc_ready = ($urandom_range(0, 3) == 0);
            clr       = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 200) == 0) begin
                rstn = 1'b0;
                model_reset();
            end else begin
                rstn = 1'b1;
            end
            tick();
        end
        rstn = 1'b1;
        clr = 1'b0;
        tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
